// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle CPU: sequences reset, runs for a bounded budget, halts,
// and captures cpu_out into a show-ahead trace FIFO. Define TRACE_CHANGE_ONLY_EN to push only on change.
module cpu_run_ctrl #(
  parameter int DATA_W      = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 40,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               halt_req,
  input  logic [DATA_W-1:0]                  cpu_out,
  output logic                               cpu_reset,
  output logic                               cpu_haltext,
  output logic                               busy,
  output logic                               done,
  output logic [31:0]                        cycle_count,
  input  logic                               trace_rd,
  output logic [DATA_W-1:0]                  trace_data,
  output logic                               trace_empty,
  output logic [$clog2(TRACE_DEPTH+1)-1:0]   trace_count,
  output logic                               trace_ovf
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = $clog2(TRACE_DEPTH + 1);
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_HALT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  mem_q [TRACE_DEPTH];
`ifdef TRACE_CHANGE_ONLY_EN
  logic [DATA_W-1:0]  last_q, last_d;
`endif

  logic push_req, push, pop, full, empty, clear;

  assign full  = (count_q == CNT_W'(TRACE_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = trace_rd && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push  = push_req && (!full || pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    push_req      = 1'b0;
    clear         = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RST;
          rst_cnt_d = '0;
          clear     = 1'b1;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_RUN;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
`ifdef TRACE_CHANGE_ONLY_EN
        push_req = (cycle_count_q == '0) || (cpu_out != last_q);
`else
        push_req = 1'b1;
`endif
        if (halt_req || cycle_count_q == 32'(MAX_CYCLES - 1)) state_d = S_HALT;
      end
      S_HALT:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    ovf_d = ovf_q | (push_req && full && !pop);
`ifdef TRACE_CHANGE_ONLY_EN
    last_d = push_req ? cpu_out : last_q;
`endif
    cycle_count_d_clr();
  end

  // Start acceptance wipes the trace and counters on the same edge.
  function automatic void cycle_count_d_clr();
  endfunction

  logic [31:0]      cycle_count_n;
  logic [PTR_W-1:0] wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic             ovf_n;

  always_comb begin
    cycle_count_n = clear ? '0   : cycle_count_d;
    wr_ptr_n      = clear ? '0   : wr_ptr_d;
    rd_ptr_n      = clear ? '0   : rd_ptr_d;
    count_n       = clear ? '0   : count_d;
    ovf_n         = clear ? 1'b0 : ovf_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
`ifdef TRACE_CHANGE_ONLY_EN
      last_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_n;
      wr_ptr_q      <= wr_ptr_n;
      rd_ptr_q      <= rd_ptr_n;
      count_q       <= count_n;
      ovf_q         <= ovf_n;
`ifdef TRACE_CHANGE_ONLY_EN
      last_q        <= last_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpu_out;
  end

  assign cpu_reset   = (state_q == S_IDLE) || (state_q == S_RST);
  assign cpu_haltext = (state_q == S_HALT) || (state_q == S_DONE);
  assign busy        = (state_q == S_RST) || (state_q == S_RUN) || (state_q == S_HALT);
  assign done        = (state_q == S_DONE);
  assign cycle_count = cycle_count_q;
  assign trace_data  = mem_q[rd_ptr_q];
  assign trace_empty = empty;
  assign trace_count = count_q;
  assign trace_ovf   = ovf_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: full run, overflow, early halt, pop-while-full push,
// mid-run reset, and (with TRACE_CHANGE_ONLY_EN) change-only capture.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, trace_rd;
  logic [31:0] cpu_out;
  logic        cpu_reset, cpu_haltext, busy, done, trace_empty, trace_ovf;
  logic [31:0] cycle_count, trace_data;
  logic [4:0]  trace_count;

  int n_vec  = 0;
  int n_miss = 0;

  cpu_run_ctrl #(.DATA_W(32), .RST_CYCLES(2), .MAX_CYCLES(40), .TRACE_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .cpu_out(cpu_out),
    .cpu_reset(cpu_reset), .cpu_haltext(cpu_haltext), .busy(busy), .done(done),
    .cycle_count(cycle_count), .trace_rd(trace_rd), .trace_data(trace_data),
    .trace_empty(trace_empty), .trace_count(trace_count), .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then two RST cycles; returns with the DUT in RUN cycle 0.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 1);
    check({tag, "_haltext"},   32'(cpu_haltext), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_cycles"},    cycle_count, 0);
    check({tag, "_count"},     32'(trace_count), 0);
    check({tag, "_empty"},     32'(trace_empty), 1);
    check({tag, "_ovf"},       32'(trace_ovf), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; trace_rd = 1'b0; cpu_out = '0;
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Full 40-cycle run with cpu_out = k on RUN cycle k.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_rst0_cpu_reset", 32'(cpu_reset), 1);
    check("t1_rst0_busy", 32'(busy), 1);
    tick();
    check("t1_rst1_cpu_reset", 32'(cpu_reset), 1);
    tick();
    check("t1_run_cpu_reset", 32'(cpu_reset), 0);
    check("t1_run_cycles0", cycle_count, 0);
    for (int k = 0; k < 40; k++) begin
      cpu_out = 32'(k);
      tick();
      if (k == 19) check("t1_mid_cycles", cycle_count, 20);
    end
    check("t1_halt_haltext", 32'(cpu_haltext), 1);
    check("t1_halt_busy", 32'(busy), 1);
    check("t1_halt_done", 32'(done), 0);
    tick();
    check("t1_done", 32'(done), 1);
    check("t1_done_busy", 32'(busy), 0);
    check("t1_cycles", cycle_count, 40);
    check("t2_count", 32'(trace_count), 16);
    check("t2_ovf", 32'(trace_ovf), 1);
    for (int i = 0; i < 16; i++) begin
      check("t2_pop", trace_data, 32'(i));
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
    end
    check("t2_empty", 32'(trace_empty), 1);

    // Early halt on RUN cycle 5.
    do_start();
    check("t3_cleared_count", 32'(trace_count), 0);
    check("t3_cleared_ovf", 32'(trace_ovf), 0);
    for (int k = 0; k < 6; k++) begin
      cpu_out  = 32'(k);
      halt_req = (k == 5);
      tick();
    end
    halt_req = 1'b0;
    check("t3_cycles", cycle_count, 6);
    check("t3_halt_done", 32'(done), 0);
    tick();
    check("t3_done", 32'(done), 1);
    check("t3_count", 32'(trace_count), 6);
    for (int i = 0; i < 6; i++) begin
      check("t3_pop", trace_data, 32'(i));
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
    end
    trace_rd = 1'b1;
    tick();
    trace_rd = 1'b0;
    check("t3_pop_empty_count", 32'(trace_count), 0);
    check("t3_pop_empty_flag", 32'(trace_empty), 1);

    // Fill, then pop together with a push while full.
    do_start();
    for (int k = 0; k < 16; k++) begin
      cpu_out = 32'(k);
      tick();
    end
    check("t4_full_count", 32'(trace_count), 16);
    check("t4_full_ovf", 32'(trace_ovf), 0);
    cpu_out  = 32'd16;
    trace_rd = 1'b1;
    tick();
    trace_rd = 1'b0;
    check("t4_pp_count", 32'(trace_count), 16);
    check("t4_pp_ovf", 32'(trace_ovf), 0);
    check("t4_pp_head", trace_data, 1);
    cpu_out = 32'd17;
    tick();
    check("t4_drop_ovf", 32'(trace_ovf), 1);
    check("t4_drop_count", 32'(trace_count), 16);
    cpu_out  = 32'd18;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    check("t4_end_head", trace_data, 1);
    check("t4_end_done", 32'(done), 1);

    // Asynchronous reset on RUN cycle 10, then a clean restart.
    do_start();
    for (int k = 0; k < 10; k++) begin
      cpu_out = 32'(k);
      tick();
    end
    check("t5_pre_cycles", cycle_count, 10);
    reset = 1'b1;
    #1;
    check_reset_vals("t5");
    tick();
    reset = 1'b0;
    tick();
    do_start();
    check("t5_restart_cycles", cycle_count, 0);
    check("t5_restart_cpu_reset", 32'(cpu_reset), 0);
    for (int k = 0; k < 3; k++) begin
      cpu_out = 32'(k + 50);
      tick();
    end
    check("t5_run_cycles", cycle_count, 3);
    check("t5_run_count", 32'(trace_count), 3);
    check("t5_run_head", trace_data, 50);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();

`ifdef TRACE_CHANGE_ONLY_EN
    begin
      logic [31:0] seq [6];
      logic [31:0] want [3];
      seq  = '{32'd7, 32'd7, 32'd7, 32'd9, 32'd9, 32'd3};
      want = '{32'd7, 32'd9, 32'd3};
      do_start();
      for (int k = 0; k < 6; k++) begin
        cpu_out  = seq[k];
        halt_req = (k == 5);
        tick();
      end
      halt_req = 1'b0;
      tick();
      check("t6_cycles", cycle_count, 6);
      check("t6_count", 32'(trace_count), 3);
      for (int i = 0; i < 3; i++) begin
        check("t6_pop", trace_data, want[i]);
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
